// File: rtl/mipi_packet_framer.sv
// rtl/mipi_packet_framer.sv - serialises one payload per frame as SOF, header, data and trailer pixel words
// Output word is decoded from the registered state, so it appears one cycle after accept.
module mipi_packet_framer #(
   parameter int          DLEN        = 6,
   parameter logic [7:0]  DTYPE       = 8'h01,
   parameter logic [7:0]  PHL_ID      = 8'h00,
   parameter int          GAP         = 2,
   parameter logic [23:0] PKT_ID_INIT = 24'h000000
) (
   input  logic              tx_pixel_clk,
   input  logic              rst,
   input  logic [DLEN*8-1:0] payload,
   input  logic              payload_valid,
   output logic              payload_ready,
   input  logic              tx_ready,
   output logic [47:0]       packet,
   output logic              packet_valid,
   output logic              busy,
   output logic [23:0]       pkt_id
);

   localparam int N     = DLEN / 6;
   localparam int PW    = DLEN * 8;
   localparam int CNT_W = $clog2(N) + 1;
   localparam int GAP_W = $clog2(GAP + 1) + 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N - 1);
   localparam logic [GAP_W-1:0] LAST_GAP  = GAP_W'(GAP - 1);
   localparam logic [31:0]      DLEN_BYTES = 32'(DLEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SOF,
      S_HDR,
      S_DATA,
      S_TRAIL,
      S_GAP
   } state_t;

   state_t           state, state_nxt;
   logic [PW-1:0]    shreg;
   logic [CNT_W-1:0] word_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [23:0]      pkt_id_q;
   logic [47:0]      chunk;

   assign payload_ready = (state == S_IDLE) && !rst;
   assign busy          = (state != S_IDLE);
   assign pkt_id        = pkt_id_q;
   assign chunk         = shreg[PW-1 -: 48];

   always_comb begin
      state_nxt    = state;
      packet       = 48'h0;
      packet_valid = 1'b0;
      case (state)
         S_IDLE: begin
            if (payload_valid) state_nxt = S_SOF;
         end
         S_SOF: begin
            packet_valid = 1'b1;
            packet       = {24'hEAFF99, pkt_id_q};
            if (tx_ready) state_nxt = S_HDR;
         end
         S_HDR: begin
            packet_valid = 1'b1;
            packet       = {DTYPE, DLEN_BYTES, PHL_ID};
            if (tx_ready) state_nxt = S_DATA;
         end
         S_DATA: begin
            // halves swapped so the receive parser reassembles the original chunk
            packet_valid = 1'b1;
            packet       = {chunk[23:0], chunk[47:24]};
            if (tx_ready && word_cnt == LAST_WORD) state_nxt = S_TRAIL;
         end
         S_TRAIL: begin
            packet_valid = 1'b1;
            if (tx_ready) state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
         end
         S_GAP: begin
            if (gap_cnt == LAST_GAP) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge tx_pixel_clk) begin
      if (rst) begin
         state    <= S_IDLE;
         shreg    <= '0;
         word_cnt <= '0;
         gap_cnt  <= '0;
         pkt_id_q <= PKT_ID_INIT;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && payload_valid) begin
            shreg    <= payload;
            word_cnt <= '0;
         end
         if (state == S_DATA && tx_ready) begin
            shreg    <= shreg << 48;
            word_cnt <= word_cnt + 1'b1;
         end
         if (state == S_TRAIL && tx_ready) begin
            pkt_id_q <= pkt_id_q + 24'd1;
            gap_cnt  <= '0;
         end
         if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mipi_packet_framer.sv
// tb/tb_mipi_packet_framer.sv - scoreboard bench for mipi_packet_framer
module tb_mipi_packet_framer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic        a_rst, a_pv, a_pr, a_txr, a_pvld, a_busy;
   logic [95:0] a_payload;
   logic [47:0] a_pkt;
   logic [23:0] a_id;

   logic        b_rst, b_pv, b_pr, b_txr, b_pvld, b_busy;
   logic [95:0] b_payload;
   logic [47:0] b_pkt;
   logic [23:0] b_id;

   logic        c_rst, c_pv, c_pr, c_txr, c_pvld, c_busy;
   logic [47:0] c_payload;
   logic [47:0] c_pkt;
   logic [23:0] c_id;

   logic [47:0] qa[$];
   logic [47:0] qb[$];
   logic [47:0] qc[$];

   mipi_packet_framer #(.DLEN(12), .DTYPE(8'h01), .PHL_ID(8'h00), .GAP(2), .PKT_ID_INIT(24'h000000)) dut_a (
      .tx_pixel_clk(clk), .rst(a_rst), .payload(a_payload), .payload_valid(a_pv),
      .payload_ready(a_pr), .tx_ready(a_txr), .packet(a_pkt), .packet_valid(a_pvld),
      .busy(a_busy), .pkt_id(a_id));

   mipi_packet_framer #(.DLEN(12), .DTYPE(8'h01), .PHL_ID(8'h00), .GAP(0), .PKT_ID_INIT(24'hFFFFFE)) dut_b (
      .tx_pixel_clk(clk), .rst(b_rst), .payload(b_payload), .payload_valid(b_pv),
      .payload_ready(b_pr), .tx_ready(b_txr), .packet(b_pkt), .packet_valid(b_pvld),
      .busy(b_busy), .pkt_id(b_id));

   mipi_packet_framer #(.DLEN(6), .DTYPE(8'h01), .PHL_ID(8'h00), .GAP(2), .PKT_ID_INIT(24'h00ABCD)) dut_c (
      .tx_pixel_clk(clk), .rst(c_rst), .payload(c_payload), .payload_valid(c_pv),
      .payload_ready(c_pr), .tx_ready(c_txr), .packet(c_pkt), .packet_valid(c_pvld),
      .busy(c_busy), .pkt_id(c_id));

   // expected word k of a frame; payload is right-aligned in p
   function automatic logic [47:0] exp_word(input logic [95:0] p, input logic [23:0] id,
                                            input int dlen, input int k);
      logic [47:0] ch;
      if (k == 0) return {24'hEAFF99, id};
      if (k == 1) return {8'h01, 32'(dlen), 8'h00};
      if (k < 2 + dlen / 6) begin
         ch = p[dlen*8-1-48*(k-2) -: 48];
         return {ch[23:0], ch[47:24]};
      end
      return 48'h0;
   endfunction

   task automatic test_reset;
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
      a_pv = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (a_pvld !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", a_pvld); end
      n_cmp++; if (a_pkt !== 48'h0) begin n_err++; $display("FAIL reset_packet got %h want 0", a_pkt); end
      n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", a_busy); end
      n_cmp++; if (a_pr !== 1'b0) begin n_err++; $display("FAIL reset_ready_in_rst got %b want 0", a_pr); end
      n_cmp++; if (a_id !== 24'h000000) begin n_err++; $display("FAIL reset_id_a got %h want 000000", a_id); end
      n_cmp++; if (b_id !== 24'hFFFFFE) begin n_err++; $display("FAIL reset_id_b got %h want fffffe", b_id); end
      n_cmp++; if (c_id !== 24'h00ABCD) begin n_err++; $display("FAIL reset_id_c got %h want 00abcd", c_id); end
      a_pv = 1'b0; a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (a_pr !== 1'b1) begin n_err++; $display("FAIL reset_ready_after got %b want 1", a_pr); end
   endtask

   task automatic test_single_frame;
      logic [47:0] e;
      int nvalid = 0, ngap = 0;
      bit done = 0;
      qa = {48'hEAFF99000000, 48'h010000000C00, 48'h334455001122, 48'h99AABB667788, 48'h0};
      a_payload = 96'h0011_2233_4455_6677_8899_AABB;
      a_txr = 1'b1; a_pv = 1'b1;
      @(posedge clk); #1;
      a_pv = 1'b0; a_payload = '1;
      for (int c = 0; c < 30 && !done; c++) begin
         @(negedge clk);
         if (a_pvld) begin
            nvalid++;
            if (qa.size() == 0) begin n_err++; n_cmp++; $display("FAIL single_extra got %h want none", a_pkt); end
            else begin
               e = qa.pop_front();
               n_cmp++; if (a_pkt !== e) begin n_err++; $display("FAIL single_word got %h want %h", a_pkt, e); end
            end
         end else if (qa.size() == 0) begin
            if (a_pr) done = 1;
            else begin
               ngap++;
               n_cmp++; if (a_pkt !== 48'h0) begin n_err++; $display("FAIL single_gap_pkt got %h want 0", a_pkt); end
            end
         end
      end
      n_cmp++; if (!done) begin n_err++; $display("FAIL single_timeout got busy want idle"); end
      n_cmp++; if (nvalid != 5) begin n_err++; $display("FAIL single_nvalid got %0d want 5", nvalid); end
      n_cmp++; if (ngap != 2) begin n_err++; $display("FAIL single_gap got %0d want 2", ngap); end
   endtask

   task automatic test_backpressure;
      logic [95:0] p = 96'h0011_2233_4455_6677_8899_AABB;
      logic [47:0] e, hdr;
      int nvalid = 0, ngap = 0, nhdr = 0, stall = 0;
      bit done = 0;
      hdr = exp_word(p, 24'd1, 12, 1);
      for (int k = 0; k < 5; k++) qa.push_back(exp_word(p, 24'd1, 12, k));
      a_payload = p; a_pv = 1'b1; a_txr = 1'b1;
      @(posedge clk); #1;
      a_pv = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (a_pvld && a_pkt == hdr) nhdr++;
         if (a_pvld && a_pkt == hdr && stall < 3) begin a_txr = 1'b0; stall++; end
         else a_txr = 1'b1;
         if (a_pvld) begin
            nvalid++;
            if (a_txr) begin
               if (qa.size() == 0) begin n_err++; n_cmp++; $display("FAIL bp_extra got %h want none", a_pkt); end
               else begin
                  e = qa.pop_front();
                  n_cmp++; if (a_pkt !== e) begin n_err++; $display("FAIL bp_word got %h want %h", a_pkt, e); end
               end
            end
         end else if (qa.size() == 0) begin
            if (a_pr) done = 1; else ngap++;
         end
      end
      a_txr = 1'b1;
      n_cmp++; if (!done) begin n_err++; $display("FAIL bp_timeout got busy want idle"); end
      n_cmp++; if (nhdr != 4) begin n_err++; $display("FAIL bp_hdr_hold got %0d want 4", nhdr); end
      n_cmp++; if (nvalid != 8) begin n_err++; $display("FAIL bp_nvalid got %0d want 8", nvalid); end
      n_cmp++; if (ngap != 2) begin n_err++; $display("FAIL bp_gap got %0d want 2", ngap); end
   endtask

   task automatic test_reset_mid_frame;
      logic [95:0] p, p2;
      logic [47:0] e;
      int nvalid = 0;
      bit done = 0;
      p  = {$urandom, $urandom, $urandom};
      p2 = {$urandom, $urandom, $urandom};
      a_payload = p; a_pv = 1'b1; a_txr = 1'b1;
      @(posedge clk); #1;
      a_pv = 1'b0;
      repeat (3) @(negedge clk);
      e = exp_word(p, 24'd2, 12, 2);
      n_cmp++; if (a_pkt !== e) begin n_err++; $display("FAIL abort_data0 got %h want %h", a_pkt, e); end
      a_rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (a_pvld !== 1'b0) begin n_err++; $display("FAIL abort_valid got %b want 0", a_pvld); end
      n_cmp++; if (a_pkt !== 48'h0) begin n_err++; $display("FAIL abort_packet got %h want 0", a_pkt); end
      n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", a_busy); end
      n_cmp++; if (a_id !== 24'h000000) begin n_err++; $display("FAIL abort_id got %h want 000000", a_id); end
      a_rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (a_pvld !== 1'b0 || a_pr !== 1'b1) begin
         n_err++; $display("FAIL abort_no_resume got valid=%b ready=%b want 0/1", a_pvld, a_pr); end
      for (int k = 0; k < 5; k++) qa.push_back(exp_word(p2, 24'd0, 12, k));
      a_payload = p2; a_pv = 1'b1;
      @(posedge clk); #1;
      a_pv = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
         @(negedge clk);
         if (a_pvld) begin
            nvalid++;
            if (qa.size() == 0) begin n_err++; n_cmp++; $display("FAIL restart_extra got %h want none", a_pkt); end
            else begin
               e = qa.pop_front();
               n_cmp++; if (a_pkt !== e) begin n_err++; $display("FAIL restart_word got %h want %h", a_pkt, e); end
            end
         end else if (qa.size() == 0 && a_pr) done = 1;
      end
      n_cmp++; if (!done || nvalid != 5) begin n_err++; $display("FAIL restart_frame got %0d words want 5", nvalid); end
   endtask

   task automatic test_back_to_back;
      logic [95:0] p;
      logic [47:0] e;
      logic [23:0] id;
      int npr = 0, nidle = 0, popped = 0;
      bit after_trail = 0, done = 0;
      p = {$urandom, $urandom, $urandom};
      for (int f = 0; f < 3; f++) begin
         id = 24'hFFFFFE + 24'(f);
         for (int k = 0; k < 5; k++) qb.push_back(exp_word(p, id, 12, k));
      end
      b_payload = p; b_txr = 1'b1; b_pv = 1'b1;
      for (int c = 0; c < 60 && !done; c++) begin
         if (after_trail) begin
            n_cmp++; if (b_pvld !== 1'b0 || b_pr !== 1'b1) begin
               n_err++; $display("FAIL b2b_idle got valid=%b ready=%b want 0/1", b_pvld, b_pr); end
            after_trail = 0;
            if (qb.size() == 0) done = 1;
         end
         if (b_pv && b_pr) npr++;
         if (npr == 3 && !b_pr) b_pv = 1'b0;
         if (b_pvld && b_txr) begin
            if (qb.size() == 0) begin n_err++; n_cmp++; $display("FAIL b2b_extra got %h want none", b_pkt); end
            else begin
               e = qb.pop_front();
               popped++;
               n_cmp++; if (b_pkt !== e) begin n_err++; $display("FAIL b2b_word got %h want %h", b_pkt, e); end
               if (popped % 5 == 0) after_trail = 1;
            end
         end else if (!b_pvld && popped > 0 && qb.size() != 0) nidle++;
         if (!done) @(negedge clk);
      end
      b_pv = 1'b0;
      n_cmp++; if (!done) begin n_err++; $display("FAIL b2b_timeout got %0d words left want 0", qb.size()); end
      n_cmp++; if (npr != 3) begin n_err++; $display("FAIL b2b_ready_cycles got %0d want 3", npr); end
      n_cmp++; if (nidle != 2) begin n_err++; $display("FAIL b2b_idle_between got %0d want 2", nidle); end
      n_cmp++; if (b_id !== 24'h000001) begin n_err++; $display("FAIL b2b_wrap_id got %h want 000001", b_id); end
   endtask

   task automatic test_loopback;
      logic [47:0] e, data_out, hlen;
      logic [23:0] cap_id;
      bit data_av = 0, done = 0;
      int widx = 0;
      data_out = '0; cap_id = '0; hlen = '0;
      for (int k = 0; k < 4; k++) qc.push_back(exp_word({48'h0, 48'hDEADBEEFCAFE}, 24'h00ABCD, 6, k));
      c_payload = 48'hDEADBEEFCAFE; c_txr = 1'b1; c_pv = 1'b1;
      @(posedge clk); #1;
      c_pv = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
         @(negedge clk);
         if (c_pvld && c_txr) begin
            if (c_pkt[47:24] == 24'hEAFF99) begin cap_id = c_pkt[23:0]; widx = 0; end
            else if (widx == 1) hlen = {16'h0, c_pkt[39:8]};
            else if (widx == 2) begin data_out = {c_pkt[23:0], c_pkt[47:24]}; data_av = 1; end
            widx++;
            if (qc.size() == 0) begin n_err++; n_cmp++; $display("FAIL loop_extra got %h want none", c_pkt); end
            else begin
               e = qc.pop_front();
               n_cmp++; if (c_pkt !== e) begin n_err++; $display("FAIL loop_word got %h want %h", c_pkt, e); end
            end
         end else if (!c_pvld && qc.size() == 0 && c_pr) done = 1;
      end
      n_cmp++; if (!done) begin n_err++; $display("FAIL loop_timeout got busy want idle"); end
      n_cmp++; if (data_av !== 1'b1) begin n_err++; $display("FAIL loop_data_available got %b want 1", data_av); end
      n_cmp++; if (data_out !== 48'hDEADBEEFCAFE) begin n_err++; $display("FAIL loop_data got %h want deadbeefcafe", data_out); end
      n_cmp++; if (cap_id !== 24'h00ABCD) begin n_err++; $display("FAIL loop_pkt_id got %h want 00abcd", cap_id); end
      n_cmp++; if (hlen !== 48'd6) begin n_err++; $display("FAIL loop_len got %0d want 6", hlen); end
   endtask

   initial begin
      a_rst = 1'b1; a_pv = 1'b0; a_txr = 1'b1; a_payload = '0;
      b_rst = 1'b1; b_pv = 1'b0; b_txr = 1'b1; b_payload = '0;
      c_rst = 1'b1; c_pv = 1'b0; c_txr = 1'b1; c_payload = '0;
      test_reset;
      test_single_frame;
      test_backpressure;
      test_reset_mid_frame;
      test_back_to_back;
      test_loopback;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mipi_packet_framer.md
Name: mipi_packet_framer

Overview:
- Transmit-side framer that builds the 48-bit pixel-word packet stream consumed by the MIPI receive-side frame parser.
- Takes one DLEN-byte payload per frame and serialises it as: SOF/packet-ID word, header word, payload words, trailer word.
- Inserts an inter-frame idle gap after each frame.
- Sits between the miner result/job source and the MIPI TX pixel interface, and on the loopback test path into the receive parser.

Parameters:
- DLEN, 6: payload bytes per frame. Must be a multiple of 6 and at least 6. N = DLEN/6 payload words.
- DTYPE, 8'h01: data-type byte placed in the header.
- PHL_ID, 8'h00: physical-lane/channel ID byte placed in the header.
- GAP, 2: idle cycles (packet_valid low) after each trailer word. 0 is legal.
- PKT_ID_INIT, 24'h000000: packet-ID value after reset.

Ports:
- tx_pixel_clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- payload  in  DLEN*8  frame payload, MSB-first.
- payload_valid  in  1  payload is presented.
- payload_ready  out  1  framer accepts payload this cycle.
- tx_ready  in  1  TX side accepts the current word.
- packet  out  48  output pixel word.
- packet_valid  out  1  packet holds a frame word.
- busy  out  1  high in every state except IDLE.
- pkt_id  out  24  ID that the next or current frame carries.

Behaviour:
- Reset (rst high at an edge) takes effect at that edge and overrides all other activity, including mid-frame:
  - state = IDLE, packet = 0, packet_valid = 0, busy = 0, pkt_id = PKT_ID_INIT.
  - The latched payload is discarded. No partial frame resumes.
- payload_ready = (state == IDLE) && !rst. It is combinational and does not depend on tx_ready.
- Accept: payload_valid && payload_ready at edge k.
  - The payload is latched into an internal shift register. Upstream may change payload from cycle k+1 onward.
  - The SOF word appears registered in cycle k+1 (1-cycle latency).
- States and transitions:
  - IDLE -> SOF on accept.
  - SOF -> HDR on tx_ready.
  - HDR -> DATA on tx_ready.
  - DATA stays in DATA until word N-1 is taken with tx_ready, then -> TRAIL.
  - TRAIL -> GAP on tx_ready, or -> IDLE on tx_ready if GAP = 0.
  - GAP -> IDLE after GAP cycles. tx_ready is ignored in GAP.
- Word formats:
  - SOF word: packet[47:24] = 24'hEAFF99, packet[23:0] = pkt_id.
  - HDR word: packet[47:40] = DTYPE, packet[39:8] = DLEN as a 32-bit byte count, packet[7:0] = PHL_ID.
  - DATA word i (i = 0..N-1): chunk = payload[DLEN*8-1-48*i -: 48]. The word is emitted half-swapped: packet = {chunk[23:0], chunk[47:24]}, so the receive parser reconstructs chunk.
  - TRAIL word: 48'h0. It must never equal the SOF pattern in [47:24].
- packet_valid is high in SOF, HDR, DATA and TRAIL, and low in IDLE and GAP. packet = 0 whenever packet_valid is low.
- Backpressure: while packet_valid && !tx_ready, packet, packet_valid and state hold unchanged.
- Word counter: width clog2(N)+1. It clears on accept and increments per accepted DATA word.
- pkt_id:
  - Increments by 1 at the edge where the TRAIL word is taken.
  - Wraps from 24'hFFFFFF to 24'h000000.
  - It is unchanged by frames aborted by reset (reset reloads PKT_ID_INIT anyway).
- Frame timing with tx_ready held high: 3+N consecutive valid words, then GAP idle cycles, then payload_ready rises.
- payload_valid outside IDLE is ignored. No queueing: the producer holds payload_valid until it sees payload_ready.

Test Plan:
- DLEN=12, payload 96'h0011_2233_4455_6677_8899_AABB, tx_ready=1 -> words 48'hEAFF99000000, 48'h010000000C00, 48'h334455001122, 48'h99AABB667788, 48'h0. Then 2 cycles with packet_valid=0, then payload_ready=1.
- Same frame with tx_ready=0 for 3 cycles while the HDR word is shown -> HDR word held stable for 4 cycles total, then the sequence continues unchanged. Total valid cycles = 8.
- PKT_ID_INIT=24'hFFFFFE, three back-to-back frames with payload_valid held high -> SOF IDs FFFFFE, FFFFFF, 000000. payload_ready is high for exactly one cycle per frame.
- rst asserted while DATA word 0 is shown -> next cycle packet_valid=0, packet=0, busy=0, pkt_id=PKT_ID_INIT. The next frame restarts with a full SOF word.
- Loopback into the receive parser with DLEN=6, payload 48'hDEADBEEFCAFE -> parser data output = 48'hDEADBEEFCAFE with data_available asserted. The parser's captured packet ID equals the pkt_id sent.
- GAP=0, two back-to-back frames -> TRAIL word followed by exactly one cycle of IDLE (packet_valid=0, payload_ready=1), then the next SOF word.
